// File: rtl/load_store_unit.sv
// load_store_unit: in-order memory stage aligning loads/stores onto an AXI4-Lite-style cache port
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic [1:0]              s_kind,
   input  logic [1:0]              s_size,
   input  logic                    s_unsigned,
   input  logic [ADDR_WIDTH-1:0]   s_addr,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [4:0]              s_rd,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic [4:0]              m_rd,
   output logic                    m_fault,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic                    wvalid,
   input  logic                    wready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    bvalid,
   output logic                    bready,
   input  logic [1:0]              bresp,
   output logic                    arvalid,
   input  logic                    arready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    rvalid,
   output logic                    rready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int OW = $clog2(SW);
   localparam int PW = $clog2(DEPTH);
   localparam logic [1:0] K_NONE  = 2'd0;
   localparam logic [1:0] K_LOAD  = 2'd1;
   localparam logic [1:0] K_STORE = 2'd2;

   typedef struct packed {
      logic [1:0]            kind;
      logic [1:0]            size;
      logic                  uns;
      logic [ADDR_WIDTH-1:0] addr;
      logic [4:0]            rd;
      logic                  fault;
   } entry_t;

   entry_t                fifo_q [DEPTH];
   entry_t                fifo_d [DEPTH];
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]           cnt_q, cnt_d;
   logic                  arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [SW-1:0]         wstrb_q, wstrb_d;
   logic                  m_tvalid_q, m_tvalid_d, m_fault_q, m_fault_d;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
   logic [4:0]            m_rd_q, m_rd_d;
   entry_t                in_e, head;
   logic [OW-1:0]         in_off, h_off;
   logic                  accept, in_nomem, empty, slot_free, h_load, h_store, h_nomem;
   logic                  done, bypass, push, h_err;
   logic [DATA_WIDTH-1:0] shifted, mask, ext;

   // Decode the incoming op, classify the FIFO head and build the aligned load result
   always_comb begin
      in_off    = s_addr[OW-1:0];
      in_e.kind = (s_kind == 2'd3) ? K_NONE : s_kind;
      in_e.size = s_size;
      in_e.uns  = s_unsigned;
      in_e.addr = s_addr;
      in_e.rd   = s_rd;
      in_e.fault = (in_e.kind != K_NONE) &
                   (((({1'b0, s_addr[2:0]}) & ((4'd1 << s_size) - 4'd1)) != 4'd0) |
                    (DATA_WIDTH == 32 && s_size == 2'd3));
      in_nomem  = in_e.fault | (in_e.kind == K_NONE);
      s_tready  = (cnt_q < (PW+1)'(DEPTH)) & ~awvalid_q & ~wvalid_q & ~arvalid_q;
      accept    = s_tvalid & s_tready;
      head      = fifo_q[rd_q];
      empty     = (cnt_q == '0);
      slot_free = ~m_tvalid_q | m_tready;
      h_load    = ~empty & ~head.fault & (head.kind == K_LOAD);
      h_store   = ~empty & ~head.fault & (head.kind == K_STORE);
      h_nomem   = ~empty & ~h_load & ~h_store;
      rready    = h_load & slot_free;
      bready    = h_store & slot_free;
      done      = slot_free & (h_nomem | (h_load & rvalid) | (h_store & bvalid));
      // an op needing no bus trip skips the FIFO when nothing is ahead of it
      bypass    = accept & in_nomem & empty & slot_free;
      push      = accept & ~bypass;
      h_err     = (h_load & (rresp != 2'd0)) | (h_store & (bresp != 2'd0));
      h_off     = head.addr[OW-1:0];
      shifted   = rdata >> {h_off, 3'b000};
      mask      = ~({DATA_WIDTH{1'b1}} << (32'd8 << head.size));
      ext       = (shifted & mask) |
                  ((~head.uns & |(shifted & mask & ~(mask >> 1))) ? ~mask : '0);
   end

   // Tracking FIFO pointers, occupancy and contents
   always_comb begin
      fifo_d = fifo_q;
      wr_d   = push ? wr_q + 1'b1 : wr_q;
      rd_d   = done ? rd_q + 1'b1 : rd_q;
      cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(done);
      if (push) fifo_d[wr_q] = in_e;
   end

   // Bus request channels: each valid holds until its own ready
   always_comb begin
      arvalid_d = arvalid_q & ~arready;
      awvalid_d = awvalid_q & ~awready;
      wvalid_d  = wvalid_q & ~wready;
      araddr_d  = araddr_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      if (accept & ~in_e.fault & (in_e.kind == K_LOAD)) begin
         arvalid_d = 1'b1;
         araddr_d  = s_addr;
      end
      if (accept & ~in_e.fault & (in_e.kind == K_STORE)) begin
         awvalid_d = 1'b1;
         wvalid_d  = 1'b1;
         awaddr_d  = s_addr;
         wdata_d   = s_wdata << {in_off, 3'b000};
         wstrb_d   = ~({SW{1'b1}} << (32'd1 << s_size)) << in_off;
      end
   end

   // Writeback output register, held stable until the sink takes it
   always_comb begin
      m_tvalid_d = m_tvalid_q & ~m_tready;
      m_data_d   = m_data_q;
      m_rd_d     = m_rd_q;
      m_fault_d  = m_fault_q;
      if (bypass) begin
         m_tvalid_d = 1'b1;
         m_rd_d     = s_rd;
         m_fault_d  = in_e.fault;
         m_data_d   = DATA_WIDTH'(s_addr);
      end else if (done) begin
         m_tvalid_d = 1'b1;
         m_rd_d     = head.rd;
         m_fault_d  = head.fault | h_err;
         m_data_d   = (h_load & ~h_err) ? ext : (h_store & ~h_err) ? '0 : DATA_WIDTH'(head.addr);
      end
   end

   // State registers
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         fifo_q     <= '{default: '0};
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         arvalid_q  <= 1'b0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         araddr_q   <= '0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         m_tvalid_q <= 1'b0;
         m_data_q   <= '0;
         m_rd_q     <= '0;
         m_fault_q  <= 1'b0;
      end else begin
         fifo_q     <= fifo_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
         arvalid_q  <= arvalid_d;
         awvalid_q  <= awvalid_d;
         wvalid_q   <= wvalid_d;
         araddr_q   <= araddr_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         m_tvalid_q <= m_tvalid_d;
         m_data_q   <= m_data_d;
         m_rd_q     <= m_rd_d;
         m_fault_q  <= m_fault_d;
      end
   end

   assign arvalid  = arvalid_q;
   assign araddr   = araddr_q;
   assign awvalid  = awvalid_q;
   assign awaddr   = awaddr_q;
   assign wvalid   = wvalid_q;
   assign wdata    = wdata_q;
   assign wstrb    = wstrb_q;
   assign m_tvalid = m_tvalid_q;
   assign m_data   = m_data_q;
   assign m_rd     = m_rd_q;
   assign m_fault  = m_fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios for the load/store unit against a simple one-cycle memory
module tb_load_store_unit;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        s_tvalid, s_tready, s_unsigned;
   logic [1:0]  s_kind, s_size;
   logic [31:0] s_addr, s_wdata;
   logic [4:0]  s_rd;
   logic        m_tvalid, m_tready, m_fault;
   logic [31:0] m_data;
   logic [4:0]  m_rd;
   logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int checks = 0, errors = 0;
   logic [31:0] rmem [16];
   int rw = 0, rr = 0, r_pend = 0, b_pend = 0;
   bit r_hold = 0, b_hold = 0, r_err = 0, b_err = 0;
   logic [31:0] od [64];
   logic [4:0]  ord [64];
   logic        of [64];
   int on = 0;
   int base;

   always #5 aclk = ~aclk;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut (
      .aclk(aclk), .areset(areset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_kind(s_kind), .s_size(s_size),
      .s_unsigned(s_unsigned), .s_addr(s_addr), .s_wdata(s_wdata), .s_rd(s_rd),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_data(m_data), .m_rd(m_rd), .m_fault(m_fault),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   assign rvalid = (r_pend > 0) && !r_hold;
   assign rdata  = rmem[rr % 16];
   assign rresp  = r_err ? 2'b10 : 2'b00;
   assign bvalid = (b_pend > 0) && !b_hold;
   assign bresp  = b_err ? 2'b10 : 2'b00;

   always @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_pend <= 0;
         b_pend <= 0;
         rr     <= rw;
      end else begin
         r_pend <= r_pend + int'(arvalid && arready) - int'(rvalid && rready);
         b_pend <= b_pend + int'(awvalid && awready) - int'(bvalid && bready);
         if (rvalid && rready) rr <= rr + 1;
      end
   end

   always @(negedge aclk) begin
      #2;
      if (m_tvalid && m_tready && on < 64) begin
         od[on]  = m_data;
         ord[on] = m_rd;
         of[on]  = m_fault;
         on++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick;
      @(negedge aclk);
      #1;
   endtask

   task automatic send(input logic [1:0] k, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
      s_tvalid = 1'b1; s_kind = k; s_size = sz; s_unsigned = u; s_addr = a; s_wdata = wd; s_rd = r;
      for (int i = 0; i < 60 && !s_tready; i++) tick;
      if (!s_tready) begin
         checks++; errors++;
         $display("FAIL send_timeout: s_tready got 0 required 1 for addr %h", a);
      end
      tick;
      s_tvalid = 1'b0;
   endtask

   task automatic wait_outs(input int n);
      for (int i = 0; i < 200 && on < n; i++) tick;
   endtask

   task automatic test_reset;
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_s_tready got %b required 1", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got %b required 0", m_tvalid); end
      checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin errors++; $display("FAIL rst_bus got %b required 00000", {arvalid, awvalid, wvalid, rready, bready}); end
      checks++; if ({m_data, m_rd, m_fault} !== 38'b0) begin errors++; $display("FAIL rst_out got %h required 0", {m_data, m_rd, m_fault}); end
   endtask

   task automatic test_load_word;
      rmem[rw % 16] = 32'h8000_00F0; rw++;
      send(2'd1, 2'd2, 1'b0, 32'h104, 32'h0, 5'd5);
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h104) begin errors++; $display("FAIL ldw_ar got %b/%h required 1/00000104", arvalid, araddr); end
      tick;
      checks++; if (rvalid !== 1'b1 || rready !== 1'b1 || m_tvalid !== 1'b0) begin errors++; $display("FAIL ldw_r got rv%b rr%b mv%b required 110", rvalid, rready, m_tvalid); end
      tick;
      checks++; if (m_tvalid !== 1'b1 || m_data !== 32'h8000_00F0 || m_fault !== 1'b0 || m_rd !== 5'd5) begin errors++; $display("FAIL ldw_out got v%b %h f%b rd%0d required v1 800000f0 f0 rd5", m_tvalid, m_data, m_fault, m_rd); end
      tick;
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ldw_drain got %b required 0", m_tvalid); end
   endtask

   task automatic test_load_extend;
      base = on;
      rmem[rw % 16] = 32'h8011_2233; rw++;
      rmem[rw % 16] = 32'h8011_2233; rw++;
      rmem[rw % 16] = 32'h0000_F234; rw++;
      send(2'd1, 2'd0, 1'b0, 32'h103, 32'h0, 5'd1);
      send(2'd1, 2'd0, 1'b1, 32'h103, 32'h0, 5'd2);
      send(2'd1, 2'd1, 1'b0, 32'h100, 32'h0, 5'd3);
      wait_outs(base + 3);
      checks++; if (on < base + 3) begin errors++; $display("FAIL ext_count got %0d required %0d", on - base, 3); end
      checks++; if (od[base] !== 32'hFFFF_FF80) begin errors++; $display("FAIL ext_sbyte got %h required ffffff80", od[base]); end
      checks++; if (od[base+1] !== 32'h0000_0080) begin errors++; $display("FAIL ext_ubyte got %h required 00000080", od[base+1]); end
      checks++; if (od[base+2] !== 32'hFFFF_F234) begin errors++; $display("FAIL ext_shalf got %h required fffff234", od[base+2]); end
   endtask

   task automatic test_store;
      send(2'd2, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD, 5'd6);
      checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h102) begin errors++; $display("FAIL sth_aw got %b%b %h required 11 00000102", awvalid, wvalid, awaddr); end
      checks++; if (wdata !== 32'hABCD_0000 || wstrb !== 4'b1100) begin errors++; $display("FAIL sth_w got %h %b required abcd0000 1100", wdata, wstrb); end
      for (int i = 0; i < 20 && !m_tvalid; i++) tick;
      checks++; if (m_tvalid !== 1'b1 || m_fault !== 1'b0 || m_data !== 32'h0 || m_rd !== 5'd6) begin errors++; $display("FAIL sth_out got v%b f%b %h rd%0d required v1 f0 0 rd6", m_tvalid, m_fault, m_data, m_rd); end
      tick;
      send(2'd2, 2'd0, 1'b0, 32'h101, 32'hFFFF_FF5A, 5'd7);
      checks++; if (wdata !== 32'hFFFF_5A00 || wstrb !== 4'b0010) begin errors++; $display("FAIL stb_w got %h %b required ffff5a00 0010", wdata, wstrb); end
      for (int i = 0; i < 20 && !m_tvalid; i++) tick;
      tick;
   endtask

   task automatic test_misalign;
      send(2'd1, 2'd2, 1'b0, 32'h101, 32'h0, 5'd3);
      checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL mis_ar got %b required 0", arvalid); end
      checks++; if (m_tvalid !== 1'b1 || m_fault !== 1'b1 || m_data !== 32'h101) begin errors++; $display("FAIL mis_out got v%b f%b %h required v1 f1 00000101", m_tvalid, m_fault, m_data); end
      send(2'd1, 2'd3, 1'b0, 32'h100, 32'h0, 5'd4);
      checks++; if (arvalid !== 1'b0 || m_fault !== 1'b1 || m_data !== 32'h100) begin errors++; $display("FAIL mis_dbl got ar%b f%b %h required ar0 f1 00000100", arvalid, m_fault, m_data); end
      send(2'd2, 2'd1, 1'b0, 32'h103, 32'h1234, 5'd5);
      checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || m_fault !== 1'b1) begin errors++; $display("FAIL mis_st got aw%b w%b f%b required 0 0 1", awvalid, wvalid, m_fault); end
      tick;
   endtask

   task automatic test_none;
      send(2'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd7);
      checks++; if (m_tvalid !== 1'b1 || m_data !== 32'hDEAD_BEEF || m_fault !== 1'b0 || m_rd !== 5'd7) begin errors++; $display("FAIL none_out got v%b %h f%b rd%0d required v1 deadbeef f0 rd7", m_tvalid, m_data, m_fault, m_rd); end
      send(2'd3, 2'd1, 1'b0, 32'h1234_5677, 32'h0, 5'd8);
      checks++; if (m_tvalid !== 1'b1 || m_data !== 32'h1234_5677 || m_fault !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL rsvd_out got v%b %h f%b ar%b required v1 12345677 f0 ar0", m_tvalid, m_data, m_fault, arvalid); end
      tick;
   endtask

   task automatic test_bus_error;
      base = on;
      r_err = 1;
      rmem[rw % 16] = 32'hCAFE_F00D; rw++;
      send(2'd1, 2'd2, 1'b0, 32'h200, 32'h0, 5'd13);
      wait_outs(base + 1);
      r_err = 0;
      b_err = 1;
      send(2'd2, 2'd2, 1'b0, 32'h600, 32'h1, 5'd14);
      wait_outs(base + 2);
      b_err = 0;
      checks++; if (on < base + 2 || od[base] !== 32'h200 || of[base] !== 1'b1) begin errors++; $display("FAIL rerr got %h f%b required 00000200 f1", od[base], of[base]); end
      checks++; if (od[base+1] !== 32'h600 || of[base+1] !== 1'b1) begin errors++; $display("FAIL berr got %h f%b required 00000600 f1", od[base+1], of[base+1]); end
      repeat (2) tick;
      checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin errors++; $display("FAIL err_consumed got rv%b bv%b required 0 0", rvalid, bvalid); end
   endtask

   task automatic test_order;
      base = on;
      rmem[rw % 16] = 32'h1111_1111; rw++;
      rmem[rw % 16] = 32'h2222_2222; rw++;
      send(2'd1, 2'd2, 1'b0, 32'h300, 32'h0, 5'd1);
      send(2'd0, 2'd0, 1'b0, 32'h55, 32'h0, 5'd2);
      send(2'd1, 2'd2, 1'b0, 32'h304, 32'h0, 5'd3);
      wait_outs(base + 3);
      checks++; if (od[base] !== 32'h1111_1111 || ord[base] !== 5'd1) begin errors++; $display("FAIL ord0 got %h rd%0d required 11111111 rd1", od[base], ord[base]); end
      checks++; if (od[base+1] !== 32'h55 || ord[base+1] !== 5'd2) begin errors++; $display("FAIL ord1 got %h rd%0d required 00000055 rd2", od[base+1], ord[base+1]); end
      checks++; if (od[base+2] !== 32'h2222_2222 || ord[base+2] !== 5'd3) begin errors++; $display("FAIL ord2 got %h rd%0d required 22222222 rd3", od[base+2], ord[base+2]); end
   endtask

   task automatic test_back_to_back;
      base = on;
      r_hold = 1;
      for (int i = 0; i < 5; i++) begin
         rmem[rw % 16] = 32'hA000_0000 + i; rw++;
      end
      for (int i = 0; i < 4; i++) send(2'd1, 2'd2, 1'b0, 32'h400 + 4 * i, 32'h0, 5'(20 + i));
      tick; tick;
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_tready got %b required 0", s_tready); end
      checks++; if (on != base) begin errors++; $display("FAIL full_held got %0d outputs required 0", on - base); end
      fork
         send(2'd1, 2'd2, 1'b0, 32'h410, 32'h0, 5'd24);
         begin repeat (3) tick; r_hold = 0; end
      join
      wait_outs(base + 5);
      checks++; if (on < base + 5) begin errors++; $display("FAIL full_count got %0d required 5", on - base); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (od[base+i] !== 32'hA000_0000 + i || ord[base+i] !== 5'(20 + i)) begin
            errors++; $display("FAIL full_out%0d got %h rd%0d required %h rd%0d", i, od[base+i], ord[base+i], 32'hA000_0000 + i, 20 + i);
         end
      end
   endtask

   task automatic test_async_reset;
      m_tready = 0;
      r_hold = 1;
      send(2'd0, 2'd0, 1'b0, 32'h77, 32'h0, 5'd9);
      send(2'd1, 2'd2, 1'b0, 32'h500, 32'h0, 5'd12);
      tick;
      arready = 0;
      send(2'd1, 2'd2, 1'b0, 32'h504, 32'h0, 5'd13);
      tick;
      checks++; if (m_tvalid !== 1'b1 || m_data !== 32'h77 || arvalid !== 1'b1) begin errors++; $display("FAIL pre_rst got v%b %h ar%b required v1 00000077 ar1", m_tvalid, m_data, arvalid); end
      areset = 1;
      #1;
      checks++; if ({arvalid, awvalid, wvalid, m_tvalid, rready, bready} !== 6'b0) begin errors++; $display("FAIL async_rst got %b required 000000", {arvalid, awvalid, wvalid, m_tvalid, rready, bready}); end
      tick;
      areset = 0;
      arready = 1;
      r_hold = 0;
      m_tready = 1;
      tick;
      checks++; if (s_tready !== 1'b1 || m_data !== 32'h0) begin errors++; $display("FAIL post_rst got tr%b %h required tr1 0", s_tready, m_data); end
      base = on;
      rmem[rw % 16] = 32'h1234_5678; rw++;
      send(2'd1, 2'd2, 1'b0, 32'h508, 32'h0, 5'd11);
      wait_outs(base + 1);
      repeat (4) tick;
      checks++; if (on != base + 1 || od[base] !== 32'h1234_5678 || ord[base] !== 5'd11) begin errors++; $display("FAIL post_rst_ld got n%0d %h rd%0d required n1 12345678 rd11", on - base, od[base], ord[base]); end
   endtask

   initial begin
      s_tvalid = 0; s_kind = 0; s_size = 0; s_unsigned = 0; s_addr = 0; s_wdata = 0; s_rd = 0;
      m_tready = 1; arready = 1; awready = 1; wready = 1;
      repeat (3) tick;
      areset = 0;
      tick;
      test_reset;
      test_load_word;
      test_load_extend;
      test_store;
      test_misalign;
      test_none;
      test_bus_error;
      test_order;
      test_back_to_back;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
